seg14_marquee_ctrl: RTL and testbench



---
 rtl/seg14_pkg.sv | 69 ++++++
 rtl/seg14_font.sv | 19 +
 rtl/seg14_marquee_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seg14_marquee_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared types and constants for the 14-segment marquee controller:
// character codes, glyph ROM contents and controller state encoding.
package seg14_pkg;

    localparam int unsigned CHAR_W = 6;
    localparam int unsigned SEG_W  = 14;

    localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
    localparam logic [CHAR_W-1:0] CH_A     = 6'd1;
    localparam logic [CHAR_W-1:0] CH_DIG0  = 6'd27;
    localparam logic [CHAR_W-1:0] CH_LAST  = 6'd36;

    // Bit 13 is segment a; order a b c d e f g1 g2 h i j k l m.
    localparam logic [SEG_W-1:0] SEG_SPACE = 14'b00000000000000;

    localparam logic [SEG_W-1:0] LETTER_ROM [26] = '{
        14'b11101111000000,  // A
        14'b11110001010010,  // B
        14'b10011100000000,  // C
        14'b11110000010010,  // D
        14'b10011110000000,  // E
        14'b10001110000000,  // F
        14'b10111101000000,  // G
        14'b01101111000000,  // H
        14'b10010000010010,  // I
        14'b01111000000000,  // J
        14'b00001110001100,  // K
        14'b00011100000000,  // L
        14'b01101100101000,  // M
        14'b01101100100100,  // N
        14'b11111100000000,  // O
        14'b11001111000000,  // P
        14'b11111100000100,  // Q
        14'b11001111000100,  // R
        14'b10110111000000,  // S
        14'b10000000010010,  // T
        14'b01111100000000,  // U
        14'b00001100001001,  // V
        14'b01101100000101,  // W
        14'b00000000101101,  // X
        14'b00000000101010,  // Y
        14'b10010000001001   // Z
    };

    localparam logic [SEG_W-1:0] DIGIT_ROM [10] = '{
        14'b11111100001001,  // 0
        14'b01100000001000,  // 1
        14'b11011011000000,  // 2
        14'b11110001000000,  // 3
        14'b01100111000000,  // 4
        14'b10010110000100,  // 5
        14'b10111111000000,  // 6
        14'b11100000000000,  // 7
        14'b11111111000000,  // 8
        14'b11110111000000   // 9
    };

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    typedef struct packed {
        logic [CHAR_W-1:0] code;
        logic              last;
    } wr_req_t;

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment glyph ROM.
// Unassigned codes (37..63) render as a blank digit.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [CHAR_W-1:0] code_i,
    output logic [SEG_W-1:0]  seg_c_o
);

    always_comb begin
        seg_c_o = SEG_SPACE;
        if (code_i >= CH_A && code_i < CH_DIG0) begin
            seg_c_o = LETTER_ROM[5'(code_i - CH_A)];
        end else if (code_i >= CH_DIG0 && code_i <= CH_LAST) begin
            seg_c_o = DIGIT_ROM[4'(code_i - CH_DIG0)];
        end
    end

endmodule

// File: rtl/seg14_marquee_ctrl.sv
// Multiplexed 14-segment marquee: buffers a host message, scans the digits
// from a prescaler and optionally scrolls the text window once per N frames.
module seg14_marquee_ctrl
    import seg14_pkg::*;
#(
    parameter int unsigned DIGITS        = 12,
    parameter int unsigned MSG_DEPTH     = 32,
    parameter int unsigned REFRESH_DIV   = 1000,
    parameter int unsigned SCROLL_FRAMES = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid_i,
    input  logic [CHAR_W-1:0] wr_char_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    input  logic              scroll_en_i,
    output logic [DIGITS-1:0] sel_o,
    output logic [SEG_W-1:0]  segm_o,
    output logic              running_o
);

    localparam int unsigned AW   = $clog2(MSG_DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned VW   = PW + 1;
    localparam int unsigned PRW  = $clog2(REFRESH_DIV);
    localparam int unsigned DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW   = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int unsigned NRED = DIGITS / 2 + 1;

    state_e            state_q, state_d;
    logic [PRW-1:0]    presc_q, presc_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [PW-1:0]     len_q, len_d;
    logic [PW-1:0]     wr_idx_q, wr_idx_d;
    logic [CHAR_W-1:0] msg_q [MSG_DEPTH];
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [SEG_W-1:0]  segm_q, segm_d;
    logic              running_q, running_d;
    logic              wr_ready_q;

    wr_req_t           wr_req;
    logic              wr_acc;
    logic              commit;
    logic [PW-1:0]     wr_slot;
    logic              tick;
    logic              frame_end;
    logic              frame_last;
    logic [VW-1:0]     vsum, vidx, lenp1;
    logic [CHAR_W-1:0] char_c;
    logic [SEG_W-1:0]  font_seg;
    logic              show;

    assign wr_req     = '{code: wr_char_i, last: wr_last_i};
    assign wr_acc     = wr_valid_i && wr_ready_q;
    assign wr_slot    = (state_q == ST_LOADING) ? wr_idx_q : '0;
    assign commit     = wr_acc && (wr_req.last || wr_slot == PW'(MSG_DEPTH - 1));
    assign tick       = (presc_q == PRW'(REFRESH_DIV - 1));
    assign frame_end  = tick && (dig_q == DW'(DIGITS - 1));
    assign frame_last = (frame_q == FW'(SCROLL_FRAMES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any accepted write either continues loading or commits
    always_comb begin
        state_d = state_q;
        if (wr_acc) begin
            state_d = commit ? ST_RUN : ST_LOADING;
        end
    end

    // Scan counters, scroll position and write pointer; commit overrides a scroll step
    always_comb begin
        presc_d  = presc_q + PRW'(1);
        dig_d    = dig_q;
        frame_d  = frame_q;
        pos_d    = pos_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        if (tick) begin
            presc_d = '0;
            dig_d   = frame_end ? '0 : dig_q + DW'(1);
        end
        if (frame_end) begin
            frame_d = frame_last ? '0 : frame_q + FW'(1);
        end
        if (frame_end && frame_last && scroll_en_i) begin
            pos_d = (pos_q == len_q) ? '0 : pos_q + PW'(1);
        end
        if (wr_acc) begin
            wr_idx_d = wr_slot + PW'(1);
        end
        if (commit) begin
            len_d   = wr_slot + PW'(1);
            pos_d   = '0;
            frame_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            dig_q      <= '0;
            frame_q    <= '0;
            pos_q      <= '0;
            len_q      <= '0;
            wr_idx_q   <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            dig_q      <= dig_d;
            frame_q    <= frame_d;
            pos_q      <= pos_d;
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            wr_ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            msg_q[wr_slot[AW-1:0]] <= wr_req.code;
        end
    end

    // Virtual index: a short message can wrap several times across the window,
    // so the modulo is a short chain of compare-and-subtract stages.
    always_comb begin
        vsum  = scroll_en_i ? (VW'(pos_q) + VW'(dig_q)) : VW'(dig_q);
        lenp1 = VW'(len_q) + VW'(1);
        vidx  = vsum;
        if (scroll_en_i) begin
            for (int unsigned i = 0; i < NRED; i++) begin
                if (vidx >= lenp1) begin
                    vidx = vidx - lenp1;
                end
            end
        end
        char_c = (vidx < VW'(len_q)) ? msg_q[vidx[AW-1:0]] : CH_SPACE;
    end

    seg14_font u_font (
        .code_i  (char_c),
        .seg_c_o (font_seg)
    );

    // Outputs: blank outside RUN and on the edge of any accepted write
    always_comb begin
        show      = (state_q == ST_RUN) && !wr_acc;
        sel_d     = show ? (DIGITS'(1) << dig_q) : '0;
        segm_d    = show ? font_seg : '0;
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            segm_q    <= '0;
            running_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            segm_q    <= segm_d;
            running_q <= running_d;
        end
    end

    assign sel_o      = sel_q;
    assign segm_o     = segm_q;
    assign running_o  = running_q;
    assign wr_ready_o = wr_ready_q;

endmodule

// File: tb/tb_seg14_marquee_ctrl.sv
// Directed self-checking bench for seg14_marquee_ctrl with a fast scan
// (REFRESH_DIV=2) and one-frame scroll steps (SCROLL_FRAMES=1).
module tb_seg14_marquee_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [5:0]  wr_char;
    logic        wr_last;
    logic        wr_ready;
    logic        scroll_en;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        running;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [5:0] C_A = 6'd1,  C_D = 6'd4,  C_E = 6'd5,  C_I = 6'd9,  C_O = 6'd15;
    localparam logic [5:0] C_P = 6'd16, C_R = 6'd18, C_S = 6'd19, C_T = 6'd20, C_U = 6'd21;

    localparam logic [13:0] P_A = 14'b11101111000000;
    localparam logic [13:0] P_D = 14'b11110000010010;
    localparam logic [13:0] P_E = 14'b10011110000000;
    localparam logic [13:0] P_I = 14'b10010000010010;
    localparam logic [13:0] P_O = 14'b11111100000000;
    localparam logic [13:0] P_P = 14'b11001111000000;
    localparam logic [13:0] P_R = 14'b11001111000100;
    localparam logic [13:0] P_S = 14'b10110111000000;
    localparam logic [13:0] P_T = 14'b10000000010010;
    localparam logic [13:0] P_U = 14'b01111100000000;

    logic [5:0]  exp_codes [12];
    logic [5:0]  list10 [10] = '{C_A, C_D, C_E, C_I, C_O, C_P, C_R, C_S, C_T, C_U};
    logic [13:0] ae_pat [3]  = '{P_A, P_E, 14'd0};

    seg14_marquee_ctrl #(
        .DIGITS        (12),
        .MSG_DEPTH     (32),
        .REFRESH_DIV   (2),
        .SCROLL_FRAMES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid_i  (wr_valid),
        .wr_char_i   (wr_char),
        .wr_last_i   (wr_last),
        .wr_ready_o  (wr_ready),
        .scroll_en_i (scroll_en),
        .sel_o       (sel),
        .segm_o      (segm),
        .running_o   (running)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pat(input logic [5:0] c);
        case (c)
            C_A: return P_A;
            C_D: return P_D;
            C_E: return P_E;
            C_I: return P_I;
            C_O: return P_O;
            C_P: return P_P;
            C_R: return P_R;
            C_S: return P_S;
            C_T: return P_T;
            C_U: return P_U;
            default: return 14'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accepted write; called at a negedge, returns at the next negedge
    task automatic put(input logic [5:0] c, input logic last);
        wr_valid = 1'b1;
        wr_char  = c;
        wr_last  = last;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_sel(input logic [11:0] want, input string tag);
        int n = 0;
        while (sel !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sel), 32'(want));
    endtask

    // Sync to a fresh digit 0 and check both dwell cycles of every digit
    task automatic scan_static(input string tag);
        logic [11:0] oh;
        wait_sel(12'h800, {tag, " sync11"});
        wait_sel(12'h001, {tag, " sync0"});
        for (int d = 0; d < 12; d++) begin
            oh = 12'd1 << d;
            for (int c = 0; c < 2; c++) begin
                check($sformatf("%s sel d%0d c%0d", tag, d, c), 32'(sel), 32'(oh));
                check($sformatf("%s segm d%0d c%0d", tag, d, c), 32'(segm), 32'(pat(exp_codes[d])));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] oh;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_char   = 6'd0;
        wr_last   = 1'b0;
        scroll_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst sel", 32'(sel), 32'h0);
        check("rst segm", 32'(segm), 32'h0);
        check("rst running", 32'(running), 32'h0);
        check("rst wr_ready", 32'(wr_ready), 32'h0);
        rst = 1'b0;
        check("wr_ready before edge", 32'(wr_ready), 32'h0);
        @(negedge clk);
        check("wr_ready after edge", 32'(wr_ready), 32'h1);
        repeat (5) @(negedge clk);
        check("empty sel", 32'(sel), 32'h0);
        check("empty segm", 32'(segm), 32'h0);
        check("empty running", 32'(running), 32'h0);

        // Static message PURO
        put(C_P, 1'b0);
        put(C_U, 1'b0);
        check("loading running", 32'(running), 32'h0);
        check("loading sel", 32'(sel), 32'h0);
        put(C_R, 1'b0);
        put(C_O, 1'b1);
        check("puro running", 32'(running), 32'h1);
        for (int d = 0; d < 12; d++) exp_codes[d] = 6'd0;
        exp_codes[0] = C_P; exp_codes[1] = C_U; exp_codes[2] = C_R; exp_codes[3] = C_O;
        scan_static("puro");

        // Scroll "AE": commit lands on the frame-wrap edge, so commit must beat the step
        scroll_en = 1'b1;
        wait_sel(12'h200, "ae sync9");
        wait_sel(12'h400, "ae sync10");
        @(negedge clk);
        put(C_A, 1'b0);
        put(C_E, 1'b1);
        check("ae blank sel", 32'(sel), 32'h0);
        check("ae running", 32'(running), 32'h1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 12; d++) begin
                oh = 12'd1 << d;
                check($sformatf("ae sel f%0d d%0d", k, d), 32'(sel), 32'(oh));
                check($sformatf("ae segm f%0d d%0d", k, d), 32'(segm), 32'(ae_pat[(k + d) % 3]));
                @(negedge clk);
                @(negedge clk);
            end
        end

        // 32 characters without wr_last: forced commit on the last slot
        scroll_en = 1'b0;
        for (int i = 0; i < 31; i++) put(list10[i % 10], 1'b0);
        check("m32 running before last", 32'(running), 32'h0);
        check("m32 wr_ready", 32'(wr_ready), 32'h1);
        put(list10[31 % 10], 1'b0);
        check("m32 running", 32'(running), 32'h1);
        for (int d = 0; d < 12; d++) exp_codes[d] = list10[d % 10];
        scan_static("m32");

        // Single-char rewrite while running
        put(C_E, 1'b1);
        check("e1 blank sel", 32'(sel), 32'h0);
        check("e1 blank segm", 32'(segm), 32'h0);
        check("e1 running", 32'(running), 32'h1);
        for (int d = 0; d < 12; d++) exp_codes[d] = 6'd0;
        exp_codes[0] = C_E;
        scan_static("e1");

        // Reset in the middle of loading
        put(C_P, 1'b0);
        put(C_U, 1'b0);
        put(C_R, 1'b0);
        check("pre-rst running", 32'(running), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst sel", 32'(sel), 32'h0);
        check("mid rst segm", 32'(segm), 32'h0);
        check("mid rst running", 32'(running), 32'h0);
        check("mid rst wr_ready", 32'(wr_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst wr_ready", 32'(wr_ready), 32'h1);
        check("post rst sel", 32'(sel), 32'h0);
        put(C_T, 1'b1);
        check("post rst running", 32'(running), 32'h1);
        for (int d = 0; d < 12; d++) exp_codes[d] = 6'd0;
        exp_codes[0] = C_T;
        scan_static("post rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
